// File: rtl/alu_flag_branch_stage_pkg.sv
// rtl/alu_flag_branch_stage_pkg.sv - shared branch encodings and width defaults for decode and execute-to-writeback
package alu_flag_branch_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 6;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_J    = 2'b01,
        BR_BRZ  = 2'b10,
        BR_BRN  = 2'b11
    } br_type_e;

endpackage

// File: rtl/alu_flag_branch_stage_if.sv
// rtl/alu_flag_branch_stage_if.sv - upstream ALU, writeback, flag and redirect signals of the stage
interface alu_flag_branch_stage_if
    import alu_flag_branch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_negative;
    logic              in_zero;
    logic              in_flag_we;
    logic              in_wb_en;
    logic [RD_W-1:0]   in_rd;
    logic [1:0]        in_br_type;
    logic [DATA_W-1:0] in_target;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wb_en;

    logic              flag_n;
    logic              flag_z;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;

    // Upstream ALU / writeback / fetch side
    modport master (
        output in_valid, in_result, in_negative, in_zero, in_flag_we, in_wb_en,
               in_rd, in_br_type, in_target, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wb_en,
               flag_n, flag_z, redirect, redirect_pc
    );

    // The stage itself
    modport slave (
        input  in_valid, in_result, in_negative, in_zero, in_flag_we, in_wb_en,
               in_rd, in_br_type, in_target, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wb_en,
               flag_n, flag_z, redirect, redirect_pc
    );

endinterface

// File: rtl/alu_flag_branch_stage_branch_resolve.sv
// rtl/alu_flag_branch_stage_branch_resolve.sv - combinational taken decision from branch type and stored flags
module alu_flag_branch_stage_branch_resolve
    import alu_flag_branch_stage_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic       taken
);

    // Decide taken from the architectural flags, never the ALU's live flags
    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_J:    taken = 1'b1;
            BR_BRZ:  taken = flag_z;
            BR_BRN:  taken = flag_n;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_branch_stage.sv
// rtl/alu_flag_branch_stage.sv - execute-to-writeback register, N/Z flag register and branch redirect
module alu_flag_branch_stage
    import alu_flag_branch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_flag_branch_stage_if.slave  bus,
    output logic [CNT_W-1:0]        taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] in_result_w;
    logic [DATA_W-1:0] in_target_w;
    logic [RD_W-1:0]   in_rd_w;
    logic              accept;
    logic              taken;

    assign in_result_w = bus.in_result;
    assign in_target_w = bus.in_target;
    assign in_rd_w     = bus.in_rd;

    // A draining entry frees the register in the same cycle, giving full throughput
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    alu_flag_branch_stage_branch_resolve u_branch_resolve (
        .br_type (bus.in_br_type),
        .flag_n  (bus.flag_n),
        .flag_z  (bus.flag_z),
        .taken   (taken)
    );

    // Writeback entry: load on accept, drop when consumed, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_rd     <= '0;
            bus.out_wb_en  <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= in_result_w;
            bus.out_rd     <= in_rd_w;
            bus.out_wb_en  <= bus.in_wb_en;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

    // N/Z update after the branch has already sampled the old values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.flag_n <= 1'b0;
            bus.flag_z <= 1'b0;
        end else if (accept && bus.in_flag_we) begin
            bus.flag_n <= bus.in_negative;
            bus.flag_z <= bus.in_zero;
        end
    end

    // One-cycle redirect pulse per taken branch; target is kept between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.redirect <= accept && taken;
            if (accept && taken) begin
                bus.redirect_pc <= in_target_w;
            end
        end
    end

    // Saturating taken-branch counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
        end else if (accept && taken && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_flag_branch_stage.sv
// tb/tb_alu_flag_branch_stage.sv - self-checking bench for alu_flag_branch_stage
module tb_alu_flag_branch_stage;
    import alu_flag_branch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_flag_branch_stage_if #(.DATA_W(32), .RD_W(6)) bus16 ();
    alu_flag_branch_stage_if #(.DATA_W(32), .RD_W(6)) bus4 ();
    logic [15:0] taken_cnt16;
    logic [3:0]  taken_cnt4;

    alu_flag_branch_stage #(.DATA_W(32), .RD_W(6), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .taken_cnt(taken_cnt16)
    );
    alu_flag_branch_stage #(.DATA_W(32), .RD_W(6), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .taken_cnt(taken_cnt4)
    );

    assign bus4.in_valid    = bus16.in_valid;
    assign bus4.in_result   = bus16.in_result;
    assign bus4.in_negative = bus16.in_negative;
    assign bus4.in_zero     = bus16.in_zero;
    assign bus4.in_flag_we  = bus16.in_flag_we;
    assign bus4.in_wb_en    = bus16.in_wb_en;
    assign bus4.in_rd       = bus16.in_rd;
    assign bus4.in_br_type  = bus16.in_br_type;
    assign bus4.in_target   = bus16.in_target;
    assign bus4.out_ready   = bus16.out_ready;

    always #5 clk = ~clk;

    // Reference model: the architectural state the stage must present
    logic        m_valid  = 1'b0;
    logic [31:0] m_result = '0;
    logic [5:0]  m_rd     = '0;
    logic        m_wb_en  = 1'b0;
    logic        m_n      = 1'b0;
    logic        m_z      = 1'b0;
    logic        m_redir  = 1'b0;
    logic [31:0] m_pc     = '0;
    int          m_taken  = 0;

    function automatic logic br_taken(input logic [1:0] br, input logic n, input logic z);
        if (br == 2'b01) return 1'b1;
        if (br == 2'b10) return z;
        if (br == 2'b11) return n;
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    logic m_ready;
    logic m_acc;
    assign m_ready = !m_valid || bus16.out_ready;
    assign m_acc   = bus16.in_valid && m_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_result <= '0; m_rd <= '0; m_wb_en <= 1'b0;
            m_n <= 1'b0; m_z <= 1'b0; m_redir <= 1'b0; m_pc <= '0; m_taken <= 0;
        end else begin
            m_redir <= m_acc && br_taken(bus16.in_br_type, m_n, m_z);
            if (m_acc) begin
                m_valid  <= 1'b1;
                m_result <= bus16.in_result;
                m_rd     <= bus16.in_rd;
                m_wb_en  <= bus16.in_wb_en;
                if (bus16.in_flag_we) begin
                    m_n <= bus16.in_negative;
                    m_z <= bus16.in_zero;
                end
                if (br_taken(bus16.in_br_type, m_n, m_z)) begin
                    m_pc    <= bus16.in_target;
                    m_taken <= m_taken + 1;
                end
            end else if (bus16.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("in_ready",    64'(bus16.in_ready),    64'(m_ready));
        chk("out_valid",   64'(bus16.out_valid),   64'(m_valid));
        chk("out_result",  64'(bus16.out_result),  64'(m_result));
        chk("out_rd",      64'(bus16.out_rd),      64'(m_rd));
        chk("out_wb_en",   64'(bus16.out_wb_en),   64'(m_wb_en));
        chk("flag_n",      64'(bus16.flag_n),      64'(m_n));
        chk("flag_z",      64'(bus16.flag_z),      64'(m_z));
        chk("redirect",    64'(bus16.redirect),    64'(m_redir));
        chk("redirect_pc", 64'(bus16.redirect_pc), 64'(m_pc));
        chk("taken_cnt16", 64'(taken_cnt16),       64'(sat(m_taken, 65535)));
        chk("taken_cnt4",  64'(taken_cnt4),        64'(sat(m_taken, 15)));
        chk("w4_out_valid", 64'(bus4.out_valid),   64'(m_valid));
        chk("w4_redirect",  64'(bus4.redirect),    64'(m_redir));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic n, input logic z,
                         input logic fwe, input logic wb, input logic [5:0] rd,
                         input br_type_e br, input logic [31:0] tgt);
        bus16.in_valid    = v;
        bus16.in_result   = res;
        bus16.in_negative = n;
        bus16.in_zero     = z;
        bus16.in_flag_we  = fwe;
        bus16.in_wb_en    = wb;
        bus16.in_rd       = rd;
        bus16.in_br_type  = br;
        bus16.in_target   = tgt;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_NONE, 32'h0);
        bus16.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Build up state, then reset mid-stream
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 6'd3, BR_NONE, 32'h0);
        bus16.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(bus16.out_valid), 64'h1);
        chk("pre_rst_n",     64'(bus16.flag_n),    64'h1);
        chk("pre_rst_z",     64'(bus16.flag_z),    64'h1);
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid",    64'(bus16.out_valid),  64'h0);
        chk("rst_result",   64'(bus16.out_result), 64'h0);
        chk("rst_n",        64'(bus16.flag_n),     64'h0);
        chk("rst_z",        64'(bus16.flag_z),     64'h0);
        chk("rst_redirect", 64'(bus16.redirect),   64'h0);
        chk("rst_cnt",      64'(taken_cnt16),      64'h0);
        chk("rst_in_ready", 64'(bus16.in_ready),   64'h1);
        tick();
        rst = 1'b0;
        bus16.out_ready = 1'b1;

        // Zero result sets Z, then BRZ is taken on the stored flag
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5, BR_NONE, 32'h0);
        tick();
        chk("t2_result", 64'(bus16.out_result), 64'h0);
        chk("t2_rd",     64'(bus16.out_rd),     64'h5);
        chk("t2_z",      64'(bus16.flag_z),     64'h1);
        chk("t2_redir0", 64'(bus16.redirect),   64'h0);
        drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7, BR_BRZ, 32'h40);
        tick();
        chk("t2_redir",  64'(bus16.redirect),    64'h1);
        chk("t2_pc",     64'(bus16.redirect_pc), 64'h40);
        chk("t2_cnt",    64'(taken_cnt16),       64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_NONE, 32'h0);
        tick();
        chk("t2_pulse_end", 64'(bus16.redirect),    64'h0);
        chk("t2_pc_hold",   64'(bus16.redirect_pc), 64'h40);

        // Backpressure for three cycles, then drain and load on one edge
        drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b1, 6'd9, BR_NONE, 32'h0);
        bus16.out_ready = 1'b0;
        tick();
        drive(1'b1, 32'hA5A5_0002, 1'b0, 1'b1, 1'b1, 1'b1, 6'd10, BR_NONE, 32'h0);
        #1;
        chk("t3_in_ready0", 64'(bus16.in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_result", 64'(bus16.out_result), 64'hA5A5_0001);
            chk("t3_hold_rd",     64'(bus16.out_rd),     64'h9);
            chk("t3_hold_z",      64'(bus16.flag_z),     64'h0);
        end
        bus16.out_ready = 1'b1;
        #1;
        chk("t3_in_ready1", 64'(bus16.in_ready), 64'h1);
        tick();
        chk("t3_new_result", 64'(bus16.out_result), 64'hA5A5_0002);
        chk("t3_new_valid",  64'(bus16.out_valid),  64'h1);
        chk("t3_new_z",      64'(bus16.flag_z),     64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_NONE, 32'h0);
        tick();
        chk("t3_drained", 64'(bus16.out_valid), 64'h0);

        // BRN that also writes N uses the old N; the next BRN sees the new one
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, BR_BRN, 32'h80);
        tick();
        chk("t4_no_redir", 64'(bus16.redirect), 64'h0);
        chk("t4_n_set",    64'(bus16.flag_n),   64'h1);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_BRN, 32'h90);
        tick();
        chk("t4_redir",    64'(bus16.redirect),    64'h1);
        chk("t4_pc",       64'(bus16.redirect_pc), 64'h90);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_BRZ, 32'hA0);
        tick();
        chk("t4_brz_not",  64'(bus16.redirect),    64'h0);
        chk("t4_pc_hold",  64'(bus16.redirect_pc), 64'h90);

        // Four back-to-back jumps give four back-to-back pulses
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b1, 6'(i), BR_J, 32'(16 * i));
            tick();
            chk("t5_redir", 64'(bus16.redirect),    64'h1);
            chk("t5_pc",    64'(bus16.redirect_pc), 64'(16 * i));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_J, 32'h99);
        tick();
        chk("t5_idle_j",  64'(bus16.redirect), 64'h0);
        chk("t5_cnt",     64'(taken_cnt16),    64'd6);

        // Seventeen more jumps saturate the narrow counter
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_J, 32'(256 + i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, BR_NONE, 32'h0);
        tick();
        chk("t6_cnt4_sat", 64'(taken_cnt4),  64'hF);
        chk("t6_cnt16",    64'(taken_cnt16), 64'd23);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
